// File: rtl/control_unit_if.sv
// Instruction/status in, decoded control word and constant out, between datapath and control unit.
// No valid/ready: the control unit decodes whatever I/status hold every cycle, with zero-cycle latency.
interface control_unit_if;
    logic [4:0]  status;
    logic [31:0] I;
    logic [36:0] control_word;
    logic [63:0] constant;

    modport master (output status, I, input control_word, constant);
    modport slave  (input status, I, output control_word, constant);
endinterface

// File: rtl/control_unit.sv
// LEGv8 single-cycle control unit: combinational decode of I into control word + constant.
// Define CU_BCOND_EN to add the condition-flag register and B.cond decode.
module control_unit (
    input  logic          clock,
    input  logic          reset,
    control_unit_if.slave cu
);
    logic [4:0]  da, sa, sb, fs;
    logic        c0, bsel, regw, ramw, en_mem, en_alu, en_pc, sl, illegal;
    logic [1:0]  ps, hw;
    logic [63:0] k;

`ifdef CU_BCOND_EN
    logic [3:0] flags;
    logic       cond_base, cond_true;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) flags <= '0;
        else if (sl) flags <= cu.status[3:0];
    end

    // flags = {V, C, N, Z}; odd codes invert the even ones, except 1111 (always)
    always_comb begin
        cond_base = 1'b1;
        case (cu.I[3:1])
            3'd0: cond_base = flags[0];
            3'd1: cond_base = flags[2];
            3'd2: cond_base = flags[1];
            3'd3: cond_base = flags[3];
            3'd4: cond_base = flags[2] & ~flags[0];
            3'd5: cond_base = (flags[1] == flags[3]);
            3'd6: cond_base = ~flags[0] & (flags[1] == flags[3]);
            default: cond_base = 1'b1;
        endcase
        cond_true = (cu.I[0] && cu.I[3:1] != 3'd7) ? ~cond_base : cond_base;
    end
`else
    logic unused_status;
    assign unused_status = ^cu.status[3:0];
`endif

    always_comb begin
        da = cu.I[4:0];
        sa = cu.I[9:5];
        sb = cu.I[20:16];
        fs = 5'b00000;
        c0 = 1'b0;
        bsel = 1'b0;
        regw = 1'b0;
        ramw = 1'b0;
        en_mem = 1'b0;
        en_alu = 1'b0;
        en_pc = 1'b0;
        ps = 2'b01;
        sl = 1'b0;
        hw = 2'b00;
        illegal = 1'b0;
        k = '0;
        casez (cu.I[31:21])
            11'b10001011000: begin fs = 5'b01000; regw = 1'b1; en_alu = 1'b1; end
            11'b10101011000: begin fs = 5'b01000; regw = 1'b1; en_alu = 1'b1; sl = 1'b1; end
            11'b11001011000: begin fs = 5'b01001; c0 = 1'b1; regw = 1'b1; en_alu = 1'b1; end
            11'b11101011000: begin fs = 5'b01001; c0 = 1'b1; regw = 1'b1; en_alu = 1'b1; sl = 1'b1; end
            11'b10001010000: begin fs = 5'b00000; regw = 1'b1; en_alu = 1'b1; end
            11'b10101010000: begin fs = 5'b00100; regw = 1'b1; en_alu = 1'b1; end
            11'b11001010000: begin fs = 5'b01100; regw = 1'b1; en_alu = 1'b1; end
            11'b1001000100?: begin
                fs = 5'b01000; bsel = 1'b1; regw = 1'b1; en_alu = 1'b1;
                k = {52'b0, cu.I[21:10]};
            end
            11'b1101000100?: begin
                fs = 5'b01001; c0 = 1'b1; bsel = 1'b1; regw = 1'b1; en_alu = 1'b1;
                k = {52'b0, cu.I[21:10]};
            end
            11'b11111000010: begin
                fs = 5'b01000; bsel = 1'b1; en_mem = 1'b1; regw = 1'b1;
                k = {{55{cu.I[20]}}, cu.I[20:12]};
            end
            11'b11111000000: begin
                fs = 5'b01000; bsel = 1'b1; ramw = 1'b1; sb = cu.I[4:0];
                k = {{55{cu.I[20]}}, cu.I[20:12]};
            end
            11'b110100101??: begin
                fs = 5'b11000; bsel = 1'b1; regw = 1'b1; en_alu = 1'b1;
                k = {48'b0, cu.I[20:5]} << {cu.I[22:21], 4'b0000};
            end
            // MOVK reads the old destination so the ALU can insert the halfword
            11'b111100101??: begin
                fs = 5'b11100; bsel = 1'b1; regw = 1'b1; en_alu = 1'b1;
                sa = cu.I[4:0]; hw = cu.I[22:21];
                k = {48'b0, cu.I[20:5]} << {cu.I[22:21], 4'b0000};
            end
            11'b000101?????: begin
                ps = 2'b10;
                k = {{38{cu.I[25]}}, cu.I[25:0]};
            end
            11'b1011010????: begin
                sa = cu.I[4:0]; sb = 5'd31; fs = 5'b11000;
                k = {{45{cu.I[23]}}, cu.I[23:5]};
                ps = (cu.status[4] == ~cu.I[24]) ? 2'b10 : 2'b01;
            end
`ifdef CU_BCOND_EN
            11'b01010100???: begin
                k = {{45{cu.I[23]}}, cu.I[23:5]};
                ps = cond_true ? 2'b10 : 2'b01;
            end
`endif
            default: begin
                da = 5'd0; sa = 5'd0; sb = 5'd0; illegal = 1'b1;
            end
        endcase
    end

    assign cu.control_word = reset ? {da, sa, sb, fs, c0, bsel, regw, ramw, en_mem, en_alu,
                                      en_pc, ps, sl, hw, illegal, 4'b0000} : '0;
    assign cu.constant = reset ? k : '0;
endmodule

// File: tb/tb_control_unit.sv
// Self-checking bench for control_unit: directed steps then randomized instructions vs a reference model.
module tb_control_unit;
  typedef enum int {K_ADD, K_ADDS, K_SUB, K_SUBS, K_AND, K_ORR, K_EOR, K_ADDI, K_SUBI,
                    K_LDUR, K_STUR, K_MOVZ, K_MOVK, K_B, K_CBZ, K_CBNZ, K_BCOND, K_ILL} kind_e;

  logic clock;
  logic reset;
  control_unit_if cu();

  control_unit dut (.clock(clock), .reset(reset), .cu(cu));

  // clock / reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  int pass_cnt = 0;
  int total = 0;
  logic [3:0] m_flags = 4'h0;
  logic [100:0] exp_q[$];

  // reference model
  function automatic kind_e classify(input logic [31:0] i);
    int unsigned o11 = i >> 21;
    int unsigned o10 = i >> 22;
    int unsigned o9  = i >> 23;
    int unsigned o8  = i >> 24;
    int unsigned o6  = i >> 26;
    if (o11 == 'b10001011000) return K_ADD;
    if (o11 == 'b10101011000) return K_ADDS;
    if (o11 == 'b11001011000) return K_SUB;
    if (o11 == 'b11101011000) return K_SUBS;
    if (o11 == 'b10001010000) return K_AND;
    if (o11 == 'b10101010000) return K_ORR;
    if (o11 == 'b11001010000) return K_EOR;
    if (o10 == 'b1001000100) return K_ADDI;
    if (o10 == 'b1101000100) return K_SUBI;
    if (o11 == 'b11111000010) return K_LDUR;
    if (o11 == 'b11111000000) return K_STUR;
    if (o9 == 'b110100101) return K_MOVZ;
    if (o9 == 'b111100101) return K_MOVK;
    if (o6 == 'b000101) return K_B;
    if (o8 == 'b10110100) return K_CBZ;
    if (o8 == 'b10110101) return K_CBNZ;
`ifdef CU_BCOND_EN
    if (o8 == 'b01010100) return K_BCOND;
`endif
    return K_ILL;
  endfunction

  function automatic longint unsigned sext(input longint unsigned v, input int n);
    longint unsigned top = 64'd1 << (n - 1);
    return (v ^ top) - top;
  endfunction

  function automatic bit cond_holds(input int c, input logic [3:0] fl);
    bit z = fl[0], n = fl[1], cc = fl[2], v = fl[3];
    case (c)
      0: return z;
      1: return !z;
      2: return cc;
      3: return !cc;
      4: return n;
      5: return !n;
      6: return v;
      7: return !v;
      8: return cc && !z;
      9: return !(cc && !z);
      10: return n == v;
      11: return n != v;
      12: return !z && (n == v);
      13: return !(!z && (n == v));
      default: return 1'b1;
    endcase
  endfunction

  function automatic void model(input logic [31:0] i, input logic [4:0] st, input logic [3:0] fl,
                                output logic [36:0] cw, output logic [63:0] k, output bit sl);
    longint unsigned iv = i;
    longint unsigned da = iv & 31, sa = (iv >> 5) & 31, sb = (iv >> 16) & 31;
    longint unsigned fs = 0, c0 = 0, bsel = 0, regw = 0, ramw = 0, en_mem = 0, en_alu = 0;
    longint unsigned ps = 1, hw = 0, ill = 0, kv = 0, slv = 0, word;
    kind_e kind = classify(i);
    case (kind)
      K_ADD:  begin fs = 8;  regw = 1; en_alu = 1; end
      K_ADDS: begin fs = 8;  regw = 1; en_alu = 1; slv = 1; end
      K_SUB:  begin fs = 9;  c0 = 1; regw = 1; en_alu = 1; end
      K_SUBS: begin fs = 9;  c0 = 1; regw = 1; en_alu = 1; slv = 1; end
      K_AND:  begin fs = 0;  regw = 1; en_alu = 1; end
      K_ORR:  begin fs = 4;  regw = 1; en_alu = 1; end
      K_EOR:  begin fs = 12; regw = 1; en_alu = 1; end
      K_ADDI: begin fs = 8; bsel = 1; regw = 1; en_alu = 1; kv = (iv >> 10) & 'hFFF; end
      K_SUBI: begin fs = 9; c0 = 1; bsel = 1; regw = 1; en_alu = 1; kv = (iv >> 10) & 'hFFF; end
      K_LDUR: begin fs = 8; bsel = 1; en_mem = 1; regw = 1; kv = sext((iv >> 12) & 'h1FF, 9); end
      K_STUR: begin fs = 8; bsel = 1; ramw = 1; sb = iv & 31; kv = sext((iv >> 12) & 'h1FF, 9); end
      K_MOVZ: begin
        fs = 24; bsel = 1; regw = 1; en_alu = 1;
        kv = ((iv >> 5) & 'hFFFF) << (16 * ((iv >> 21) & 3));
      end
      K_MOVK: begin
        fs = 28; bsel = 1; regw = 1; en_alu = 1; sa = iv & 31; hw = (iv >> 21) & 3;
        kv = ((iv >> 5) & 'hFFFF) << (16 * ((iv >> 21) & 3));
      end
      K_B: begin ps = 2; kv = sext(iv & 'h3FFFFFF, 26); end
      K_CBZ, K_CBNZ: begin
        sa = iv & 31; sb = 31; fs = 24; kv = sext((iv >> 5) & 'h7FFFF, 19);
        ps = (st[4] == (kind == K_CBZ)) ? 2 : 1;
      end
      K_BCOND: begin
        kv = sext((iv >> 5) & 'h7FFFF, 19);
        ps = cond_holds(int'(iv & 15), fl) ? 2 : 1;
      end
      default: begin da = 0; sa = 0; sb = 0; ill = 1; end
    endcase
    word = (da << 32) | (sa << 27) | (sb << 22) | (fs << 17) | (c0 << 16) | (bsel << 15) |
           (regw << 14) | (ramw << 13) | (en_mem << 12) | (en_alu << 11) | (ps << 8) |
           (slv << 7) | (hw << 5) | (ill << 4);
    cw = word[36:0];
    k = kv;
    sl = (slv != 0);
  endfunction

  function automatic logic [31:0] gen_instr();
    logic [31:0] r = $urandom;
    case ($urandom_range(0, 17))
      0: r[31:21] = 11'b10001011000;
      1: r[31:21] = 11'b10101011000;
      2: r[31:21] = 11'b11001011000;
      3: r[31:21] = 11'b11101011000;
      4: r[31:21] = 11'b10001010000;
      5: r[31:21] = 11'b10101010000;
      6: r[31:21] = 11'b11001010000;
      7: r[31:22] = 10'b1001000100;
      8: r[31:22] = 10'b1101000100;
      9: r[31:21] = 11'b11111000010;
      10: r[31:21] = 11'b11111000000;
      11: r[31:23] = 9'b110100101;
      12: r[31:23] = 9'b111100101;
      13: r[31:26] = 6'b000101;
      14: r[31:24] = 8'b10110100;
      15: r[31:24] = 8'b10110101;
      16: r[31:24] = 8'b01010100;
      default: ;
    endcase
    return r;
  endfunction

  // scoreboard
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    total++;
    assert (obs === expv) pass_cnt++;
    else $error("FAIL %s: got %h expected %h", tag, obs, expv);
  endtask

  task automatic check_outputs(input string tag);
    logic [100:0] e;
    if (exp_q.size() == 0) begin
      total++;
      $error("FAIL %s: expected queue empty", tag);
    end else begin
      e = exp_q.pop_front();
      check({tag, "_cw"}, 64'(cu.control_word), 64'(e[100:64]));
      check({tag, "_const"}, cu.constant, e[63:0]);
    end
  endtask

  // drivers
  task automatic step(input string tag, input logic [31:0] i, input logic [4:0] s);
    logic [36:0] ecw;
    logic [63:0] ek;
    bit esl;
    @(posedge clock);
    #1;
    cu.I = i;
    cu.status = s;
    model(i, s, m_flags, ecw, ek, esl);
    if (!reset) begin
      ecw = '0;
      ek = '0;
    end
    exp_q.push_back({ecw, ek});
    @(negedge clock);
    check_outputs(tag);
    if (reset && esl) m_flags = s[3:0];
  endtask

  // reset pulse started between edges, so any pending flag load must be lost
  task automatic pulse_reset();
    #1;
    reset = 1'b0;
    m_flags = 4'h0;
    #1;
    check("rst_cw", 64'(cu.control_word), 64'd0);
    check("rst_const", cu.constant, 64'd0);
    cu.I = 32'h0;
    cu.status = 5'h0;
    @(posedge clock);
    #2;
    reset = 1'b1;
  endtask

  initial begin
    reset = 1'b0;
    cu.I = 32'h0;
    cu.status = 5'h0;
    #3;
    check("reset_cw", 64'(cu.control_word), 64'd0);
    check("reset_const", cu.constant, 64'd0);
    step("reset_addi", 32'h91000821, 5'h0);
    @(posedge clock);
    #2;
    reset = 1'b1;

    step("addi", 32'h91000821, 5'h0);
    check("addi_fields", 64'({cu.control_word[36:27], cu.control_word[21:17], cu.control_word[15:14],
                              cu.control_word[11], cu.control_word[9:8]}),
          64'({5'd1, 5'd1, 5'b01000, 2'b11, 1'b1, 2'b01}));
    check("addi_k", cu.constant, 64'd2);

    step("sub", 32'hCB010000, 5'h0);
    check("sub_fields", 64'({cu.control_word[36:16], cu.control_word[14]}),
          64'({5'd0, 5'd0, 5'd1, 5'b01001, 1'b1, 1'b1}));

    step("adds_c", 32'hAB020022, 5'h04);
    check("adds_sl", 64'(cu.control_word[7]), 64'd1);
    step("bcond_hs", 32'h54000002, 5'h00);
`ifdef CU_BCOND_EN
    check("bcond_hs_ps", 64'(cu.control_word[9:8]), 64'd2);
`else
    check("bcond_illegal", 64'(cu.control_word), 64'h110);
`endif
    step("bcond_mi_no", 32'h54000004, 5'h00);
    step("adds_n", 32'hAB020022, 5'h02);
    step("bcond_mi", 32'h54000004, 5'h00);
`ifdef CU_BCOND_EN
    check("bcond_mi_ps", 64'(cu.control_word[9:8]), 64'd2);
`endif

    step("stur", 32'hF8001023, 5'h0);
    check("stur_fields", 64'({cu.control_word[31:22], cu.control_word[15:13]}),
          64'({5'd1, 5'd3, 1'b1, 1'b0, 1'b1}));
    check("stur_k", cu.constant, 64'd1);

    step("movz", 32'hD2800021, 5'h0);
    check("movz_fs", 64'(cu.control_word[21:17]), 64'b11000);
    check("movz_k", cu.constant, 64'd1);
    step("movk", 32'hF2800021, 5'h0);
    check("movk_fields", 64'({cu.control_word[36:27], cu.control_word[21:17], cu.control_word[6:5]}),
          64'({5'd1, 5'd1, 5'b11100, 2'b00}));

    step("cbz_taken", 32'hB4000041, 5'h10);
    check("cbz_ps", 64'(cu.control_word[9:8]), 64'd2);
    check("cbz_k", cu.constant, 64'd2);
    step("cbnz_not", 32'hB5000041, 5'h10);
    step("b_neg", 32'h17FFFFFF, 5'h0);
    step("illegal", 32'hFFFFFFFF, 5'h1F);

    // flags loaded by SUBS must be discarded by a reset before the edge
    step("subs_z", 32'hEB020022, 5'h01);
    pulse_reset();
    step("bcond_eq", 32'h54000000, 5'h00);
`ifdef CU_BCOND_EN
    check("eq_after_reset_ps", 64'(cu.control_word[9:8]), 64'd1);
`endif

    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 49) == 0) pulse_reset();
      step($sformatf("rand%0d", n), gen_instr(), 5'($urandom));
    end

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end
endmodule
